slice_stream: RTL

Parametrised frame slicer for the Viterbi decoder front end. It accepts fixed-width received-code frames over a valid/ready handshake and splits each frame into beats of `SYM_PER_CYC` received symbols. Each symbol is 2 bits (rate 1/2) or 3 bits (rate 1/3). Beats go to the branch-metric unit with backpressure. After the final frame of a stream is fully delivered, the block raises a delayed end-of-data flag (`o_ood`) that stays aligned with the downstream pipeline.

---
 rtl/slice_pkg.sv | 21 ++
 rtl/param_def.sv | 8 +
 rtl/slice_lane_mux.sv | 56 +++++
 rtl/slice_stream.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/slice_pkg.sv
// Shared types and helpers for the frame slicer.
//   slice_state_t   : slicer control states
//   beats_per_frame : number of output beats a frame splits into
//   LANE_W          : bits per output lane (wide enough for rate 1/3)
package slice_pkg;

  localparam int unsigned LANE_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } slice_state_t;

  function automatic int unsigned beats_per_frame(input int unsigned frame_w,
                                                  input int unsigned sym,
                                                  input int unsigned n);
    return frame_w / (sym * n);
  endfunction

endpackage

// File: rtl/param_def.sv
// Code-rate encodings shared by the Viterbi front end.
//   CODE_RATE_2 : rate 1/2, two bits per received symbol
//   CODE_RATE_3 : rate 1/3, three bits per received symbol
`ifndef PARAM_DEF_SV
`define PARAM_DEF_SV
`define CODE_RATE_2 1'b0
`define CODE_RATE_3 1'b1
`endif

// File: rtl/slice_lane_mux.sv
// Combinational beat extractor: picks SYM_PER_CYC symbols starting at bit
// pointer i_ptr (MSB-first) from the held frame and packs them into lanes.
// Build option SLICE_RATE3_EN adds rate 1/3 extraction; without it every
// beat is sliced as rate 1/2 and i_rate3 is ignored.
//   i_frame : held frame, MSB is first received bit
//   i_ptr   : frame bit index of the first bit of this beat
//   i_rate3 : 1 selects 3-bit symbols
//   o_beat  : lane k in o_beat[3k+2:3k], symbol bit j in lane bit j
module slice_lane_mux
  import slice_pkg::*;
#(
  parameter  int unsigned FRAME_W     = 48,
  parameter  int unsigned SYM_PER_CYC = 2,
  localparam int unsigned PTR_W       = $clog2(FRAME_W),
  localparam int unsigned BEAT_W      = LANE_W * SYM_PER_CYC
) (
  input  logic [FRAME_W-1:0] i_frame,
  input  logic [PTR_W-1:0]   i_ptr,
  input  logic               i_rate3,
  output logic [BEAT_W-1:0]  o_beat
);

  logic [PTR_W-1:0]   sh_c;
  logic [FRAME_W-1:0] aligned_c;
  logic [BEAT_W-1:0]  beat_r2_c;

  // Move the beat's first bit to the frame MSB so lane taps are constant.
  assign sh_c      = PTR_W'(FRAME_W - 1) - i_ptr;
  assign aligned_c = i_frame << sh_c;

  // Rate 1/2: two bits per lane, lane bit 2 unused.
  for (genvar k = 0; k < SYM_PER_CYC; k++) begin : g_r2
    assign beat_r2_c[LANE_W*k +: LANE_W] =
      {1'b0, aligned_c[FRAME_W-2-2*k], aligned_c[FRAME_W-1-2*k]};
  end

`ifdef SLICE_RATE3_EN
  logic [BEAT_W-1:0] beat_r3_c;
  logic              unused_low_c;

  // Rate 1/3: three bits per lane.
  for (genvar k = 0; k < SYM_PER_CYC; k++) begin : g_r3
    assign beat_r3_c[LANE_W*k +: LANE_W] =
      {aligned_c[FRAME_W-3-3*k], aligned_c[FRAME_W-2-3*k], aligned_c[FRAME_W-1-3*k]};
  end

  assign o_beat       = i_rate3 ? beat_r3_c : beat_r2_c;
  assign unused_low_c = ^aligned_c[FRAME_W-3*SYM_PER_CYC-1:0];
`else
  logic unused_low_c;

  assign o_beat       = beat_r2_c;
  assign unused_low_c = i_rate3 ^ (^aligned_c[FRAME_W-2*SYM_PER_CYC-1:0]);
`endif

endmodule

// File: rtl/slice_stream.sv
// Frame slicer for the Viterbi front end. Accepts FRAME_W-bit frames over a
// valid/ready handshake and emits SYM_PER_CYC symbols per beat to the
// branch-metric unit; after the last frame of a stream it raises a sticky,
// delayed end-of-data flag.
// Build option SLICE_RATE3_EN: compiles in rate 1/3 slicing. Without it,
// rate 1/3 frames are sliced as rate 1/2 and flag o_cfg_err.
//   clk, rst (sync, active-low), en_s (0 freezes everything)
//   i_frame_valid/o_frame_ready, i_data_frame, i_code_rate, i_frame_last
//   o_rx/o_rx_valid/i_rx_ready : beat stream, lane k = o_rx[3k+2:3k]
//   o_ood     : end of data, sticky until reset
//   o_cfg_err : rate 1/3 requested in a build without it, sticky
`ifndef PARAM_DEF_SV
`include "param_def.sv"
`endif

module slice_stream
  import slice_pkg::*;
#(
  parameter int unsigned FRAME_W     = 48,
  parameter int unsigned SYM_PER_CYC = 2,
  parameter int unsigned OOD_DELAY   = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en_s,
  input  logic                          i_code_rate,
  input  logic                          i_frame_valid,
  input  logic                          i_frame_last,
  input  logic [FRAME_W-1:0]            i_data_frame,
  output logic                          o_frame_ready,
  output logic [LANE_W*SYM_PER_CYC-1:0] o_rx,
  output logic                          o_rx_valid,
  input  logic                          i_rx_ready,
  output logic                          o_ood,
  output logic                          o_cfg_err
);

  localparam int unsigned BEAT_W = LANE_W * SYM_PER_CYC;
  localparam int unsigned PTR_W  = $clog2(FRAME_W);
  localparam int unsigned B2     = beats_per_frame(FRAME_W, SYM_PER_CYC, 2);
  localparam int unsigned B3     = beats_per_frame(FRAME_W, SYM_PER_CYC, 3);
  localparam int unsigned BIDX_W = (B2 > 1) ? $clog2(B2) : 1;
  localparam int unsigned DL_LEN = (OOD_DELAY > 1) ? OOD_DELAY - 1 : 1;

  if ((FRAME_W % (2*SYM_PER_CYC)) != 0 || (FRAME_W % (3*SYM_PER_CYC)) != 0) begin : g_bad_frame_w
    $error("slice_stream: FRAME_W must be divisible by 2*SYM_PER_CYC and 3*SYM_PER_CYC");
  end
  if (OOD_DELAY > 7) begin : g_bad_ood_delay
    $error("slice_stream: OOD_DELAY must be in 0..7");
  end

  slice_state_t       state_q, state_d;
  logic [BIDX_W-1:0]  b_q, b_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               rate3_q, rate3_d;
  logic               last_q, last_d;
  logic               ood_q, ood_d;

  logic               active_c, run_c, at_last_c, rate3_req_c;
  logic               rx_hs_c, frame_hs_c, fin_hs_c, ood_set_c;
  logic [BIDX_W-1:0]  b_last_c;
  logic [PTR_W-1:0]   ofs_c, ptr_c;
  logic [BEAT_W-1:0]  beat_c;

  // Handshake qualification; reset and enable gate both directions.
  assign active_c    = rst && en_s;
  assign run_c       = (state_q == ST_RUN);
  assign b_last_c    = rate3_q ? BIDX_W'(B3 - 1) : BIDX_W'(B2 - 1);
  assign at_last_c   = (b_q == b_last_c);
  assign rate3_req_c = (i_code_rate == `CODE_RATE_3);

  assign o_rx_valid    = active_c && run_c;
  // Next frame may be taken while the final beat of a non-last frame leaves.
  assign o_frame_ready = active_c && ((state_q == ST_IDLE) ||
                         (run_c && at_last_c && i_rx_ready && !last_q));

  assign rx_hs_c    = o_rx_valid && i_rx_ready;
  assign frame_hs_c = i_frame_valid && o_frame_ready;
  assign fin_hs_c   = rx_hs_c && at_last_c && last_q;

  // Bit pointer of the current beat's first bit.
  assign ofs_c = PTR_W'(32'(b_q) * SYM_PER_CYC * (rate3_q ? 32'd3 : 32'd2));
  assign ptr_c = PTR_W'(FRAME_W - 1) - ofs_c;

  slice_lane_mux #(
    .FRAME_W     (FRAME_W),
    .SYM_PER_CYC (SYM_PER_CYC)
  ) u_lane_mux (
    .i_frame (frame_q),
    .i_ptr   (ptr_c),
    .i_rate3 (rate3_q),
    .o_beat  (beat_c)
  );

  assign o_rx = o_rx_valid ? beat_c : '0;

  // Control next-state.
  always_comb begin
    state_d = state_q;
    b_d     = b_q;
    frame_d = frame_q;
    rate3_d = rate3_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: ;
      ST_RUN: begin
        if (rx_hs_c) begin
          if (at_last_c) begin
            state_d = last_q ? ST_DONE : ST_IDLE;
          end else begin
            b_d = b_q + BIDX_W'(1);
          end
        end
      end
      ST_DONE: ;
      default: state_d = ST_IDLE;
    endcase
    // Accept overrides: legal only from IDLE or on a non-last final beat.
    if (frame_hs_c) begin
      state_d = ST_RUN;
      b_d     = '0;
      frame_d = i_data_frame;
      last_d  = i_frame_last;
`ifdef SLICE_RATE3_EN
      rate3_d = rate3_req_c;
`else
      rate3_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      b_q     <= '0;
      frame_q <= '0;
      rate3_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      frame_q <= frame_d;
      rate3_q <= rate3_d;
      last_q  <= last_d;
    end
  end

  // End-of-data delay: short delays set the flag at the final handshake,
  // longer ones pass through a shift line that only advances when enabled.
  if (OOD_DELAY <= 1) begin : g_ood_short
    assign ood_set_c = fin_hs_c;
  end else begin : g_ood_line
    logic [DL_LEN-1:0] dl_q, dl_d;

    always_comb begin
      dl_d = dl_q;
      if (en_s) dl_d = DL_LEN'({dl_q, fin_hs_c});
    end

    always_ff @(posedge clk) begin
      if (!rst) dl_q <= '0;
      else      dl_q <= dl_d;
    end

    assign ood_set_c = en_s && dl_q[DL_LEN-1];
  end

  always_comb begin
    ood_d = ood_q | ood_set_c;
  end

  always_ff @(posedge clk) begin
    if (!rst) ood_q <= 1'b0;
    else      ood_q <= ood_d;
  end

  assign o_ood = ood_q;

`ifdef SLICE_RATE3_EN
  assign o_cfg_err = 1'b0;
`else
  logic cfg_err_q, cfg_err_d;

  // Rate 1/3 request without rate 1/3 support.
  always_comb begin
    cfg_err_d = cfg_err_q | (frame_hs_c && rate3_req_c);
  end

  always_ff @(posedge clk) begin
    if (!rst) cfg_err_q <= 1'b0;
    else      cfg_err_q <= cfg_err_d;
  end

  assign o_cfg_err = cfg_err_q;
`endif

endmodule
